muldiv32_unit: RTL and testbench

Iterative 32-bit unsigned multiply/divide unit sitting directly upstream of the 32-entry register file's write port. It takes two operands read from the register file (RD1/RD2), computes a product half, quotient or remainder over multiple cycles, and presents a one-cycle write request (enable, address, data) that drives the register file's WERF/WA/WD. While an operation is in flight it asserts `busy` so the control path stalls issue.

---
 rtl/muldiv32_unit.sv | 115 +++++++++++
 tb/tb_muldiv32_unit.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/muldiv32_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | muldiv32_unit : iterative 32-bit unsigned MUL/MULHU/DIVU/REMU unit that  |
// |                 issues a one-cycle register-file write with the result.  |
// | Revision      : 1.0                                                      |
// +--------------------------------------------------------------------------+
module muldiv32_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] opa,
  input  logic [XLEN-1:0] opb,
  input  logic [4:0]      wa_in,
  output logic            busy,
  output logic            werf_out,
  output logic [4:0]      wa_out,
  output logic [XLEN-1:0] wd_out
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [5:0] c_last = 6'(XLEN - 1);

  state_t              r_state;
  logic [1:0]          r_op;
  logic [XLEN-1:0]     r_a;
  logic [XLEN-1:0]     r_b;
  logic [4:0]          r_wa;
  logic [5:0]          r_count;
  logic [2*XLEN-1:0]   r_acc;

  logic [XLEN:0]       w_sum;
  logic [XLEN:0]       w_prem;
  logic [XLEN-1:0]     w_diff;
  logic [XLEN-1:0]     w_rem;
  logic                w_ge;

  // Multiply: add the multiplicand into the high half, then shift the whole product right.
  assign w_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, (r_b[0] ? r_a : {XLEN{1'b0}})};

  // Divide: high half is the partial remainder, low half collects quotient bits.
  assign w_prem = {r_acc[2*XLEN-1:XLEN], r_a[XLEN-1]};
  assign w_ge   = (w_prem >= {1'b0, r_b});
  assign w_diff = w_prem[XLEN-1:0] - r_b;
  assign w_rem  = w_ge ? w_diff : w_prem[XLEN-1:0];

  // The write cycle itself still counts as busy so issue stays stalled until it retires.
  assign busy = (r_state != S_IDLE) || werf_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_op     <= 2'd0;
      r_a      <= '0;
      r_b      <= '0;
      r_wa     <= 5'd0;
      r_count  <= 6'd0;
      r_acc    <= '0;
      werf_out <= 1'b0;
      wa_out   <= 5'd0;
      wd_out   <= '0;
    end else begin
      werf_out <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_op    <= op;
            r_a     <= opa;
            r_b     <= opb;
            r_wa    <= wa_in;
            r_count <= 6'd0;
            if (op[1] && (opb == '0)) begin
              r_acc   <= {opa, {XLEN{1'b1}}};
              r_state <= S_DONE;
            end else begin
              r_acc   <= '0;
              r_state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (r_op[1]) begin
            r_acc <= {w_rem, r_acc[XLEN-2:0], w_ge};
            r_a   <= r_a << 1;
          end else begin
            r_acc <= {w_sum, r_acc[XLEN-1:1]};
            r_b   <= r_b >> 1;
          end
          r_count <= r_count + 6'd1;
          if (r_count == c_last) begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          werf_out <= 1'b1;
          wa_out   <= r_wa;
          wd_out   <= r_op[0] ? r_acc[2*XLEN-1:XLEN] : r_acc[XLEN-1:0];
          r_state  <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_muldiv32_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_muldiv32_unit : self-checking bench for muldiv32_unit                 |
// | Revision         : 1.0                                                   |
// +--------------------------------------------------------------------------+
module tb_muldiv32_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [31:0] opa = 32'd0;
  logic [31:0] opb = 32'd0;
  logic [4:0]  wa_in = 5'd0;
  logic        busy;
  logic        werf_out;
  logic [4:0]  wa_out;
  logic [31:0] wd_out;

  int n_checks = 0;
  int n_fail   = 0;

  muldiv32_unit #(.XLEN(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op       (op),
    .opa      (opa),
    .opb      (opb),
    .wa_in    (wa_in),
    .busy     (busy),
    .werf_out (werf_out),
    .wa_out   (wa_out),
    .wd_out   (wd_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Reference result straight from the arithmetic definition of each op.
  function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    p = 64'(a) * 64'(b);
    case (o)
      2'd0:    return p[31:0];
      2'd1:    return p[63:32];
      2'd2:    return (b == 0) ? 32'hFFFF_FFFF : a / b;
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Called at a falling edge; returns at the falling edge of the write cycle.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] w, input bit poke);
    int          lat;
    int          nbusy;
    int          nwe;
    int          at;
    logic [31:0] got_wd;
    logic [4:0]  got_wa;
    lat    = (o[1] && b == 0) ? 1 : 33;
    nbusy  = 0;
    nwe    = 0;
    at     = -1;
    got_wd = 32'd0;
    got_wa = 5'd0;
    start = 1'b1; op = o; opa = a; opb = b; wa_in = w;
    @(posedge clk);
    #1;
    start = 1'b0;
    op    = 2'($urandom);
    opa   = $urandom;
    opb   = $urandom;
    wa_in = 5'($urandom);
    for (int k = 0; k <= lat; k++) begin
      @(negedge clk);
      if (busy) nbusy++;
      if (werf_out) begin
        nwe++;
        at     = k;
        got_wd = wd_out;
        got_wa = wa_out;
      end
      if (poke && k == 9) begin
        start = 1'b1; op = 2'd0; opa = 32'h55; opb = 32'h3; wa_in = 5'd9;
      end else begin
        start = 1'b0;
      end
    end
    chk("busy_cycles", 64'(nbusy), 64'(lat + 1));
    chk("werf_count", 64'(nwe), 64'd1);
    chk("werf_latency", 64'(at), 64'(lat));
    chk("wa_out", 64'(got_wa), 64'(w));
    chk("wd_out", 64'(got_wd), 64'(model(o, a, b)));
  endtask

  task automatic idle(input int n);
    int act;
    act = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (busy || werf_out) act++;
    end
    chk("idle_quiet", 64'(act), 64'd0);
  endtask

  initial begin
    int nwe;
    logic [1:0]  ro;
    logic [31:0] ra;
    logic [31:0] rb;

    repeat (2) @(negedge clk);
    chk("reset_outputs", {26'd0, busy, werf_out, wa_out, wd_out}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(2'd0, 32'd7, 32'd6, 5'd5, 1'b0);
    idle(2);
    run_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 1'b0);
    run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 1'b0);
    run_op(2'd2, 32'd100, 32'd7, 5'd3, 1'b0);
    run_op(2'd3, 32'd100, 32'd7, 5'd4, 1'b0);
    run_op(2'd2, 32'h8000_0000, 32'd1, 5'd6, 1'b0);
    run_op(2'd3, 32'h8000_0000, 32'd1, 5'd7, 1'b0);
    run_op(2'd2, 32'h1234, 32'd0, 5'd8, 1'b0);
    run_op(2'd3, 32'h1234, 32'd0, 5'd0, 1'b0);
    idle(1);

    // Second start mid-operation must be ignored; the next one on busy-fall is taken.
    run_op(2'd0, 32'h0001_2345, 32'h0000_6789, 5'd4, 1'b1);
    run_op(2'd1, 32'hDEAD_BEEF, 32'h1234_5678, 5'd11, 1'b0);
    idle(2);

    // Asynchronous reset during a divide aborts it with no write.
    start = 1'b1; op = 2'd2; opa = 32'd1000; opb = 32'd3; wa_in = 5'd12;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int k = 0; k < 15; k++) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrun_reset_outputs", {26'd0, busy, werf_out, wa_out, wd_out}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    nwe = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (werf_out || busy) nwe++;
    end
    chk("no_write_after_reset", 64'(nwe), 64'd0);

    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 255)) : $urandom;
      case ($urandom_range(0, 4))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 15));
        2:       rb = 32'hFFFF_FFFF;
        default: rb = $urandom;
      endcase
      run_op(ro, ra, rb, 5'($urandom), 1'b0);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: got no completion expected end of test");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
